prog_loader: RTL and testbench

- Byte-stream program loader: the write side of the instruction ROM the processor fetches from.
- Receives a framed program image over a valid/ready byte interface and packs bytes into 32-bit words.
- Writes each word into the instruction memory write port.
- Holds the processor in reset until a complete, checksum-verified image has been written.

---
 rtl/prog_loader_pkg.sv | 21 ++
 rtl/prog_loader_packer.sv | 30 +++
 rtl/prog_loader.sv | 141 ++++++++++++++
 tb/tb_prog_loader.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/prog_loader_pkg.sv
// Shared definitions for the program loader: FSM state type and default frame marker.
package prog_loader_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN_HI,
    S_LEN_LO,
    S_DATA,
    S_CSUM,
    S_DONE,
    S_ERR
  } state_t;

  localparam logic [7:0] DEFAULT_SYNC = 8'hA5;

  // States that wait for a sync byte rather than consuming frame fields.
  function automatic logic is_rest(input state_t s);
    return (s == S_IDLE) || (s == S_DONE) || (s == S_ERR);
  endfunction

endpackage

// File: rtl/prog_loader_packer.sv
// Big-endian byte-to-word packer; word_valid pulses the cycle after the 4th byte of a word.
module byte_packer (
  input  logic        clk,
  input  logic        rst,
  input  logic        clear,
  input  logic        shift_en,
  input  logic [7:0]  byte_in,
  output logic [31:0] word,
  output logic [1:0]  byte_cnt,
  output logic        word_valid
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      word       <= '0;
      byte_cnt   <= '0;
      word_valid <= 1'b0;
    end else begin
      word_valid <= shift_en && !clear && (byte_cnt == 2'd3);
      if (clear) begin
        word     <= '0;
        byte_cnt <= '0;
      end else if (shift_en) begin
        word     <= {word[23:0], byte_in};
        byte_cnt <= byte_cnt + 2'd1;
      end
    end
  end

endmodule

// File: rtl/prog_loader.sv
// Framed byte-stream loader: writes a program image into instruction memory and
// holds the processor in reset until a checksum-verified image has landed.
module prog_loader
  import prog_loader_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int unsigned MAX_WORDS   = 1024,
  parameter logic [7:0]  SYNC_BYTE   = DEFAULT_SYNC,
  parameter int unsigned TIMEOUT_CYC = 65535
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  output logic        imem_we,
  output logic [31:0] imem_addr,
  output logic [31:0] imem_wdata,
  output logic        cpu_rst,
  output logic        load_done,
  output logic        load_err
);

  localparam int unsigned IW = $clog2(MAX_WORDS + 1);
  localparam int unsigned TW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [IW-1:0] IDX_ONE = 1;
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYC - 1);

  state_t        state;
  logic [7:0]    len_hi;
  logic [IW-1:0] n_words;
  logic [IW-1:0] index;
  logic [7:0]    csum;
  logic [TW-1:0] idle_cnt;

  logic          accept;
  logic          start;
  logic          shift_en;
  logic [31:0]   len_full;
  logic [1:0]    byte_cnt;
  logic          word_last;

  assign accept    = rx_valid && rx_ready;
  assign start     = accept && (rx_data == SYNC_BYTE) && is_rest(state);
  assign shift_en  = accept && (state == S_DATA);
  assign word_last = shift_en && (byte_cnt == 2'd3);
  assign len_full  = {16'h0000, len_hi, rx_data};

  byte_packer u_packer (
    .clk        (clk),
    .rst        (rst),
    .clear      (start),
    .shift_en   (shift_en),
    .byte_in    (rx_data),
    .word       (imem_wdata),
    .byte_cnt   (byte_cnt),
    .word_valid (imem_we)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      rx_ready  <= 1'b0;
      imem_addr <= BASE_ADDR;
      cpu_rst   <= 1'b1;
      load_done <= 1'b0;
      load_err  <= 1'b0;
      len_hi    <= '0;
      n_words   <= '0;
      index     <= '0;
      csum      <= '0;
      idle_cnt  <= '0;
    end else begin
      rx_ready <= 1'b1;
      case (state)
        S_IDLE, S_DONE, S_ERR: begin
          if (start) begin
            state     <= S_LEN_HI;
            csum      <= '0;
            index     <= '0;
            cpu_rst   <= 1'b1;
            load_done <= 1'b0;
            load_err  <= 1'b0;
          end
        end
        S_LEN_HI: begin
          if (accept) begin
            len_hi <= rx_data;
            state  <= S_LEN_LO;
          end
        end
        S_LEN_LO: begin
          if (accept) begin
            n_words <= len_full[IW-1:0];
            if (len_full > MAX_WORDS) begin
              state    <= S_ERR;
              load_err <= 1'b1;
            end else if (len_full == 32'd0) begin
              state <= S_CSUM;
            end else begin
              state <= S_DATA;
            end
          end
        end
        S_DATA: begin
          if (accept) csum <= csum ^ rx_data;
          if (word_last) begin
            imem_addr <= BASE_ADDR + (32'(index) << 2);
            index     <= index + IDX_ONE;
            if (index == n_words - IDX_ONE) state <= S_CSUM;
          end
        end
        S_CSUM: begin
          if (accept) begin
            if (rx_data == csum) begin
              state     <= S_DONE;
              cpu_rst   <= 1'b0;
              load_done <= 1'b1;
            end else begin
              state    <= S_ERR;
              load_err <= 1'b1;
            end
          end
        end
        default: state <= S_IDLE;
      endcase

      // Inter-byte watchdog; only acts on idle cycles, so it never collides with the case above.
      if (is_rest(state) || accept) begin
        idle_cnt <= '0;
      end else if (idle_cnt == TO_LAST) begin
        idle_cnt <= '0;
        state    <= S_ERR;
        load_err <= 1'b1;
      end else begin
        idle_cnt <= idle_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_prog_loader.sv
// Self-checking bench for prog_loader: frame table plus scoreboard of expected memory writes.
module tb_prog_loader;

  localparam int unsigned TO = 64;
  localparam logic [31:0] BASE = 32'h0000_0000;
  localparam int unsigned MAXW = 1024;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic        imem_we;
  logic [31:0] imem_addr;
  logic [31:0] imem_wdata;
  logic        cpu_rst;
  logic        load_done;
  logic        load_err;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [127:0] bytes;
    int unsigned  nbytes;
    bit           gaps;
    bit           exp_done;
    bit           exp_err;
  } vec_t;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  vec_t vecs[8];
  wr_t  exp_q[$];

  prog_loader #(
    .TIMEOUT_CYC (TO)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .rx_ready   (rx_ready),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .cpu_rst    (cpu_rst),
    .load_done  (load_done),
    .load_err   (load_err)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", nm, act, req);
    end
  endtask

  // Scoreboard consumer: every write strobe must match the next expected write.
  always @(negedge clk) begin
    if (!rst && imem_we) begin
      if (exp_q.size() == 0) begin
        check("unexpected_write", imem_addr, 32'hFFFF_FFFF);
      end else begin
        wr_t w;
        w = exp_q.pop_front();
        check("write_addr", imem_addr, w.addr);
        check("write_data", imem_wdata, w.data);
      end
    end
  end

  function automatic logic [7:0] byte_at(input vec_t v, input int unsigned k);
    return v.bytes[127 - 8*k -: 8];
  endfunction

  task automatic push_expected(input vec_t v);
    int unsigned n;
    wr_t w;
    n = {byte_at(v, 1), byte_at(v, 2)};
    if (n > MAXW) return;
    for (int unsigned i = 0; i < n; i++) begin
      if (3 + 4*i + 3 < v.nbytes) begin
        w.addr = BASE + 32'(4*i);
        w.data = {byte_at(v, 3+4*i), byte_at(v, 4+4*i), byte_at(v, 5+4*i), byte_at(v, 6+4*i)};
        exp_q.push_back(w);
      end
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
  endtask

  task automatic run_case(input int unsigned idx);
    vec_t v;
    v = vecs[idx];
    push_expected(v);
    for (int unsigned k = 0; k < v.nbytes; k++) begin
      if (v.gaps) repeat ($urandom_range(0, 3)) @(posedge clk);
      if (v.gaps) #1;
      send_byte(byte_at(v, k));
      if (k == 0) begin
        check($sformatf("c%0d_start_cpu_rst", idx), 32'(cpu_rst), 32'd1);
        check($sformatf("c%0d_start_done", idx), 32'(load_done), 32'd0);
        check($sformatf("c%0d_start_err", idx), 32'(load_err), 32'd0);
      end
    end
    check($sformatf("c%0d_load_done", idx), 32'(load_done), 32'(v.exp_done));
    check($sformatf("c%0d_load_err", idx), 32'(load_err), 32'(v.exp_err));
    check($sformatf("c%0d_cpu_rst", idx), 32'(cpu_rst), 32'(!v.exp_done));
    repeat (3) @(posedge clk);
    #1;
    check($sformatf("c%0d_pending_writes", idx), 32'(exp_q.size()), 32'd0);
    exp_q.delete();
  endtask

  initial begin
    vecs[0] = '{128'hA5_00_02_DE_AD_BE_EF_00_00_00_13_31_00_00_00_00, 12, 1'b0, 1'b1, 1'b0};
    vecs[1] = '{128'hA5_00_02_DE_AD_BE_EF_00_00_00_13_30_00_00_00_00, 12, 1'b0, 1'b0, 1'b1};
    vecs[2] = '{128'hA5_00_02_DE_AD_BE_EF_00_00_00_13_31_00_00_00_00, 12, 1'b1, 1'b1, 1'b0};
    vecs[3] = '{128'hA5_00_00_00_00_00_00_00_00_00_00_00_00_00_00_00, 4, 1'b0, 1'b1, 1'b0};
    vecs[4] = '{128'hA5_04_01_00_00_00_00_00_00_00_00_00_00_00_00_00, 3, 1'b0, 1'b0, 1'b1};
    vecs[5] = '{128'hA5_00_01_A5_A5_A5_A5_00_00_00_00_00_00_00_00_00, 8, 1'b0, 1'b1, 1'b0};
    vecs[6] = '{128'hA5_00_00_01_00_00_00_00_00_00_00_00_00_00_00_00, 4, 1'b0, 1'b0, 1'b1};
    vecs[7] = '{128'hA5_00_01_12_34_56_78_08_00_00_00_00_00_00_00_00, 8, 1'b1, 1'b1, 1'b0};

    rst      = 1'b1;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    check("rst_rx_ready", 32'(rx_ready), 32'd0);
    check("rst_cpu_rst", 32'(cpu_rst), 32'd1);
    check("rst_imem_we", 32'(imem_we), 32'd0);
    check("rst_imem_addr", imem_addr, BASE);
    check("rst_load_done", 32'(load_done), 32'd0);
    check("rst_load_err", 32'(load_err), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rel_rx_ready_first", 32'(rx_ready), 32'd0);
    @(posedge clk);
    #1;
    check("rel_rx_ready_second", 32'(rx_ready), 32'd1);
    repeat (4) @(posedge clk);
    #1;
    check("idle_cpu_rst", 32'(cpu_rst), 32'd1);
    check("idle_load_done", 32'(load_done), 32'd0);

    for (int unsigned i = 0; i < 8; i++) run_case(i);

    // Timeout after a partial word: ERR exactly TO idle cycles after the last accept.
    send_byte(8'hA5);
    send_byte(8'h00);
    send_byte(8'h01);
    send_byte(8'hDE);
    repeat (TO - 1) @(posedge clk);
    #1;
    check("to_not_yet", 32'(load_err), 32'd0);
    @(posedge clk);
    #1;
    check("to_load_err", 32'(load_err), 32'd1);
    check("to_cpu_rst", 32'(cpu_rst), 32'd1);
    repeat (3) @(posedge clk);
    #1;
    check("to_no_write", 32'(exp_q.size()), 32'd0);

    // Reset mid-word, then a stray byte in IDLE, then a full frame from BASE.
    send_byte(8'hA5);
    send_byte(8'h00);
    send_byte(8'h01);
    send_byte(8'hDE);
    send_byte(8'hAD);
    #2;
    rst = 1'b1;
    #1;
    check("mid_rst_cpu_rst", 32'(cpu_rst), 32'd1);
    check("mid_rst_rx_ready", 32'(rx_ready), 32'd0);
    check("mid_rst_addr", imem_addr, BASE);
    check("mid_rst_wdata", imem_wdata, 32'd0);
    check("mid_rst_err", 32'(load_err), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    send_byte(8'h55);
    check("stray_cpu_rst", 32'(cpu_rst), 32'd1);
    run_case(0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
